// File: rtl/serial_addsub_pkg.sv
// Shared definitions for the bit-serial add/subtract sequencer:
// controller state encoding and operation encoding.
package serial_addsub_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/half_adder.sv
// Half adder gate primitive: sum = a ^ b, carry = a & b.
module half_adder (
    input  logic a,
    input  logic b,
    output logic sum,
    output logic carry
);
    assign sum   = a ^ b;
    assign carry = a & b;
endmodule

// File: rtl/half_subtractor.sv
// Half subtractor gate primitive: diff = a ^ b, borrow = ~a & b.
module half_subtractor (
    input  logic a,
    input  logic b,
    output logic diff,
    output logic borrow
);
    assign diff   = a ^ b;
    assign borrow = ~a & b;
endmodule

// File: rtl/serial_bit_cell.sv
// One-bit add/subtract cell, purely combinational.
// A full adder (two half adders + OR) and a full subtractor (two half
// subtractors + OR) are both built; op selects which pair of outputs is used.
// For subtraction cin/cout carry the borrow.
module serial_bit_cell
    import serial_addsub_pkg::*;
(
    input  logic x,
    input  logic y,
    input  logic cin,
    input  logic op,
    output logic s,
    output logic cout
);
    logic ha0_s, ha0_c, ha1_s, ha1_c;
    logic hs0_d, hs0_b, hs1_d, hs1_b;

    half_adder u_ha0 (.a(x),     .b(y),   .sum(ha0_s), .carry(ha0_c));
    half_adder u_ha1 (.a(ha0_s), .b(cin), .sum(ha1_s), .carry(ha1_c));

    half_subtractor u_hs0 (.a(x),     .b(y),   .diff(hs0_d), .borrow(hs0_b));
    half_subtractor u_hs1 (.a(hs0_d), .b(cin), .diff(hs1_d), .borrow(hs1_b));

    // Select the adder or subtractor result for the current operation
    always_comb begin
        if (op == OP_SUB) begin
            s    = hs1_d;
            cout = hs0_b | hs1_b;
        end else begin
            s    = ha1_s;
            cout = ha0_c | ha1_c;
        end
    end
endmodule

// File: rtl/serial_addsub_ctrl.sv
// Bit-serial add/subtract sequencer. One shared serial_bit_cell processes a
// WIDTH-bit operand pair LSB first, one bit per clock.
// start/done handshake: start is accepted only in IDLE or DONE; done pulses
// for exactly one cycle when result/cout are valid; start while busy is
// dropped (no queueing, operands not re-latched).
// Optional macro SERIAL_ADDSUB_OVF_EN adds a signed-overflow output ovf.
module serial_addsub_ctrl
    import serial_addsub_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout
`ifdef SERIAL_ADDSUB_OVF_EN
    ,
    output logic             ovf
`endif
);
    state_e             state_q, state_d;
    logic               op_q, op_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               cout_q, cout_d;
    logic               carry_q, carry_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               accept;
    logic               last_bit;
    logic               cell_s, cell_c;

    assign accept   = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

    serial_bit_cell u_cell (
        .x    (a_q[cnt_q]),
        .y    (b_q[cnt_q]),
        .cin  (carry_q),
        .op   (op_q),
        .s    (cell_s),
        .cout (cell_c)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start)    state_d = ST_RUN;
            ST_RUN:  if (last_bit) state_d = ST_DONE;
            ST_DONE: state_d = start ? ST_RUN : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Handshake outputs decoded from state
    always_comb begin
        busy = (state_q == ST_RUN);
        done = (state_q == ST_DONE);
    end

    // Datapath: latch operands on accept, then one result bit per RUN cycle
    always_comb begin
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        cout_d   = cout_q;
        carry_d  = carry_q;
        cnt_d    = cnt_q;
        if (accept) begin
            op_d    = op;
            a_d     = a;
            b_d     = b;
            carry_d = 1'b0;
            cnt_d   = '0;
        end else if (state_q == ST_RUN) begin
            result_d[cnt_q] = cell_s;
            carry_d         = cell_c;
            if (last_bit) begin
                cout_d = cell_c;
                cnt_d  = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q     <= OP_ADD;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            carry_q  <= carry_d;
            cnt_q    <= cnt_d;
        end
    end

    assign result = result_q;
    assign cout   = cout_q;

`ifdef SERIAL_ADDSUB_OVF_EN
    logic ovf_q, ovf_d;

    // Signed overflow, evaluated on the MSB step (cell_s is result MSB then)
    always_comb begin
        ovf_d = ovf_q;
        if (!accept && (state_q == ST_RUN) && last_bit) begin
            if (op_q == OP_SUB)
                ovf_d = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (cell_s != a_q[WIDTH-1]);
            else
                ovf_d = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (cell_s != a_q[WIDTH-1]);
        end
    end

    // Overflow register, held until the next completed operation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ovf_q <= 1'b0;
        else        ovf_q <= ovf_d;
    end

    assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_serial_addsub_ctrl.sv
// Self-checking bench for serial_addsub_ctrl (WIDTH = 8): table vectors,
// hand-written multi-cycle sequences and randomized operations checked
// against an arithmetic reference model.
module tb_serial_addsub_ctrl;
    localparam int WIDTH = 8;
    localparam int MAXS  = (1 << (WIDTH - 1)) - 1;
    localparam int MINS  = -(1 << (WIDTH - 1));

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic             op_i;
    logic [WIDTH-1:0] a_i, b_i;
    logic             busy, done;
    logic [WIDTH-1:0] result;
    logic             cout;
`ifdef SERIAL_ADDSUB_OVF_EN
    logic             ovf;
`endif

    int checks   = 0;
    int failures = 0;

    // {ovf, cout, result} expected per accepted operation
    logic [WIDTH+1:0] exp_q[$];

    typedef struct {
        string            name;
        logic             op;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] res;
        logic             c;
        logic             v;
    } vec_t;

    vec_t tbl[8];

    serial_addsub_ctrl #(.WIDTH(WIDTH)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op     (op_i),
        .a      (a_i),
        .b      (b_i),
        .busy   (busy),
        .done   (done),
        .result (result),
        .cout   (cout)
`ifdef SERIAL_ADDSUB_OVF_EN
        ,
        .ovf    (ovf)
`endif
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain modular/signed arithmetic
    function automatic logic [WIDTH+1:0] model(input logic o, input logic [WIDTH-1:0] x,
                                               input logic [WIDTH-1:0] y);
        int sx, sy, sr;
        logic [WIDTH:0] wide;
        logic ov;
        sx = $signed(x);
        sy = $signed(y);
        if (o == 1'b0) begin
            wide = {1'b0, x} + {1'b0, y};
            sr   = sx + sy;
        end else begin
            wide = {1'b0, x} - {1'b0, y};
            sr   = sx - sy;
        end
        ov = (sr > MAXS) || (sr < MINS);
        return {ov, wide};
    endfunction

    // driver: present a request at the current (negedge) point
    task automatic drive_start(input logic o, input logic [WIDTH-1:0] x,
                               input logic [WIDTH-1:0] y, input logic [WIDTH+1:0] e);
        start = 1'b1;
        op_i  = o;
        a_i   = x;
        b_i   = y;
        exp_q.push_back(e);
    endtask

    // Follow one operation from its start edge to its done cycle
    task automatic watch(input string name, input bit inject, input bit idle_after);
        int bad = 0;
        logic [WIDTH+1:0] e;
        for (int k = 1; k <= WIDTH; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (inject && k == 3) begin
                start = 1'b1;
                op_i  = 1'b1;
                a_i   = '0;
                b_i   = '0;
            end else begin
                op_i = 1'($urandom);
                a_i  = WIDTH'($urandom);
                b_i  = WIDTH'($urandom);
            end
            if (busy !== 1'b1 || done !== 1'b0) bad++;
        end
        check({name, " busy_window"}, bad, 0);
        @(negedge clk);
        start = 1'b0;
        check({name, " done"}, {31'd0, done}, 1);
        check({name, " busy_at_done"}, {31'd0, busy}, 0);
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s: got done expected no pending op", name);
        end else begin
            e = exp_q.pop_front();
            check({name, " result"}, {24'd0, result}, {24'd0, e[WIDTH-1:0]});
            check({name, " cout"}, {31'd0, cout}, {31'd0, e[WIDTH]});
`ifdef SERIAL_ADDSUB_OVF_EN
            check({name, " ovf"}, {31'd0, ovf}, {31'd0, e[WIDTH+1]});
`endif
        end
        if (idle_after) begin
            @(negedge clk);
            check({name, " done_single"}, {31'd0, done}, 0);
            check({name, " idle_after"}, {31'd0, busy}, 0);
        end
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, " busy"}, {31'd0, busy}, 0);
        check({name, " done"}, {31'd0, done}, 0);
        check({name, " result"}, {24'd0, result}, 0);
        check({name, " cout"}, {31'd0, cout}, 0);
`ifdef SERIAL_ADDSUB_OVF_EN
        check({name, " ovf"}, {31'd0, ovf}, 0);
`endif
    endtask

    initial begin
        int gap;
        int done_seen;
        logic o;
        logic [WIDTH-1:0] x, y;

        tbl[0] = '{"add_5a_3c",   1'b0, 8'h5A, 8'h3C, 8'h96, 1'b0, 1'b1};
        tbl[1] = '{"add_wrap",    1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0};
        tbl[2] = '{"sub_borrow",  1'b1, 8'h10, 8'h20, 8'hF0, 1'b1, 1'b0};
        tbl[3] = '{"sub_ovf",     1'b1, 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1};
        tbl[4] = '{"add_zero",    1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0};
        tbl[5] = '{"add_pos_ovf", 1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1};
        tbl[6] = '{"sub_0_1",     1'b1, 8'h00, 8'h01, 8'hFF, 1'b1, 1'b0};
        tbl[7] = '{"sub_equal",   1'b1, 8'hA5, 8'hA5, 8'h00, 1'b0, 1'b0};

        // reset block
        rst_n = 1'b0;
        start = 1'b0;
        op_i  = 1'b0;
        a_i   = '0;
        b_i   = '0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // table-driven vectors
        for (int i = 0; i < 8; i++) begin
            drive_start(tbl[i].op, tbl[i].a, tbl[i].b, {tbl[i].v, tbl[i].c, tbl[i].res});
            watch(tbl[i].name, 1'b0, 1'b1);
        end

        // start during RUN is dropped; then back-to-back start in the DONE cycle
        @(negedge clk);
        drive_start(1'b0, 8'h5A, 8'h3C, {1'b1, 1'b0, 8'h96});
        watch("mid_start", 1'b1, 1'b0);
        drive_start(1'b0, 8'hFF, 8'h01, {1'b0, 1'b1, 8'h00});
        watch("back_to_back", 1'b0, 1'b1);

        // reset in RUN cycle 4 abandons the operation
        drive_start(1'b1, 8'h10, 8'h20, {1'b0, 1'b1, 8'hF0});
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        void'(exp_q.pop_back());
        @(negedge clk);
        rst_n = 1'b1;
        done_seen = 0;
        for (int k = 0; k < WIDTH + 3; k++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) done_seen++;
        end
        check("mid_reset no_done", done_seen, 0);
        drive_start(1'b1, 8'h80, 8'h01, {1'b1, 1'b0, 8'h7F});
        watch("after_reset", 1'b0, 1'b1);

        // randomized operations, random idle gaps (0 = back-to-back)
        for (int n = 0; n < 30; n++) begin
            o = 1'($urandom);
            x = WIDTH'($urandom);
            y = WIDTH'($urandom_range(0, 3) == 0 ? x : $urandom);
            drive_start(o, x, y, model(o, x, y));
            watch($sformatf("rand%0d", n), 1'b0, 1'b0);
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                @(negedge clk);
                check($sformatf("rand%0d idle_done", n), {31'd0, done}, 0);
            end
        end
        @(negedge clk);
        start = 1'b0;
        check("final queue_empty", exp_q.size(), 0);

        // report
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
